mem_port_arbiter: RTL and testbench

Arbiter and sequencer that shares one single-ported unified memory between the Fetch Unit (instruction reads) and the Memory Access Unit (data reads and writes). It sits between the pipeline and the memory, one transaction outstanding at a time. Data requests win by default, and a starvation counter bounds how long fetch can be locked out. A per-requester response path routes read data back, and a fetch-discard mechanism drops responses for fetches that were flushed.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// One transaction outstanding; data wins unless fetch has been starved STARVE_MAX grants.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [1:0]      d_wlen,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [1:0]      mem_wlen,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state_r;
  logic              owner_fetch_r;
  logic              discard_r;
  logic [3:0]        starve_cnt_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [XLEN-1:0]   mem_addr_r;
  logic [XLEN-1:0]   mem_wdata_r;
  logic [1:0]        mem_wlen_r;
  logic              if_rvalid_r;
  logic              d_rvalid_r;
  logic [XLEN-1:0]   if_rdata_r;
  logic [XLEN-1:0]   d_rdata_r;

  logic              starved_s;
  logic              fetch_wins_s;
  logic              accept_s;
  logic              drop_fetch_s;

  assign starved_s    = (starve_cnt_r == 4'(STARVE_MAX));
  assign fetch_wins_s = if_req && (!d_req || starved_s);
  assign accept_s     = (state_r == ISSUE) && mem_ready;
  // A flush arriving with the response still kills it, not just a flush seen earlier.
  assign drop_fetch_s = discard_r || if_flush;

  assign if_gnt    = accept_s && owner_fetch_r;
  assign d_gnt     = accept_s && !owner_fetch_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wlen  = mem_wlen_r;
  assign if_rvalid = if_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign d_rvalid  = d_rvalid_r;
  assign d_rdata   = d_rdata_r;

  // Sequencer FSM with registered memory payload, starvation counter and response routing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= IDLE;
      owner_fetch_r <= 1'b0;
      discard_r     <= 1'b0;
      starve_cnt_r  <= 4'd0;
      mem_req_r     <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= {XLEN{1'b0}};
      mem_wdata_r   <= {XLEN{1'b0}};
      mem_wlen_r    <= 2'b00;
      if_rvalid_r   <= 1'b0;
      d_rvalid_r    <= 1'b0;
      if_rdata_r    <= {XLEN{1'b0}};
      d_rdata_r     <= {XLEN{1'b0}};
    end else begin
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          discard_r <= 1'b0;
          if (if_req || d_req) begin
            owner_fetch_r <= fetch_wins_s;
            mem_req_r     <= 1'b1;
            state_r       <= ISSUE;
            if (fetch_wins_s) begin
              mem_we_r    <= 1'b0;
              mem_addr_r  <= if_addr;
              mem_wdata_r <= {XLEN{1'b0}};
              mem_wlen_r  <= 2'b00;
            end else begin
              mem_we_r    <= d_we;
              mem_addr_r  <= d_addr;
              mem_wdata_r <= d_wdata;
              mem_wlen_r  <= d_wlen;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (owner_fetch_r && if_flush) begin
            discard_r <= 1'b1;
          end else begin
            discard_r <= discard_r;
          end
          if (mem_ready) begin
            mem_req_r <= 1'b0;
            if (owner_fetch_r) begin
              starve_cnt_r <= 4'd0;
            end else if (if_req && !starved_s) begin
              starve_cnt_r <= starve_cnt_r + 4'd1;
            end else begin
              starve_cnt_r <= starve_cnt_r;
            end
            state_r <= mem_we_r ? IDLE : WAIT;
          end else begin
            state_r <= ISSUE;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state_r <= IDLE;
            if (owner_fetch_r) begin
              if (!drop_fetch_s) begin
                if_rvalid_r <= 1'b1;
                if_rdata_r  <= mem_rdata;
              end else begin
                if_rvalid_r <= 1'b0;
              end
            end else begin
              d_rvalid_r <= 1'b1;
              d_rdata_r  <= mem_rdata;
            end
          end else if (owner_fetch_r && if_flush) begin
            discard_r <= 1'b1;
          end else begin
            state_r <= WAIT;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand-written corner sequences,
// with a response scoreboard fed at mem_rvalid and drained at if_rvalid/d_rvalid.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_wlen, mem_wlen;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wlen(d_wlen),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wlen(mem_wlen), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // flush: 0 none, 1 with response, 2 first WAIT cycle, 3 first ISSUE cycle, 4 in IDLE
  typedef struct {
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  wlen;
    int          ready_dly;
    int          rv_dly;
    logic [31:0] rdata;
    int          flush;
  } vec_t;

  typedef struct {
    bit          fetch;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic if_pend, d_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every rvalid pulse must match the oldest expected response.
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (rstn && (if_rvalid || d_rvalid)) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL rsp_unexpected: if_rvalid=%0b d_rvalid=%0b, expected no response", if_rvalid, d_rvalid);
      end else begin
        e = exp_q.pop_front();
        check("rsp_port", 32'({if_rvalid, d_rvalid}), e.fetch ? 32'd2 : 32'd1);
        check("rsp_data", e.fetch ? if_rdata : d_rdata, e.data);
      end
    end
  end

  // Requesters must hold req until gnt.
  always @(negedge clk) begin
    if (!rstn) begin
      if_pend <= 1'b0;
      d_pend  <= 1'b0;
    end else begin
      assert (!(if_pend && !if_req)) else $error("FAIL hold_if: if_req dropped before if_gnt");
      assert (!(d_pend && !d_req)) else $error("FAIL hold_d: d_req dropped before d_gnt");
      if_pend <= if_req && !if_gnt;
      d_pend  <= d_req && !d_gnt;
    end
  end

  // Called at #1 after a rising edge with the arbiter idle; returns the same way.
  task automatic txn(input vec_t v);
    if (v.fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wlen = v.wlen;
    end
    if_flush  = (v.flush == 4);
    mem_ready = 1'b0;
    @(negedge clk);
    check("idle_mem_req", 32'(mem_req), 32'd0);
    for (int k = 1; k <= v.ready_dly + 1; k++) begin
      @(posedge clk); #1;
      mem_ready = (k == v.ready_dly + 1);
      if_flush  = (v.flush == 3 && k == 1);
      @(negedge clk);
      check("mem_req", 32'(mem_req), 32'd1);
      check("mem_addr", mem_addr, v.addr);
      check("mem_we", 32'(mem_we), 32'(v.fetch ? 1'b0 : v.we));
      if (!v.fetch && v.we) begin
        check("mem_wdata", mem_wdata, v.wdata);
        check("mem_wlen", 32'(mem_wlen), 32'(v.wlen));
      end
      check("if_gnt", 32'(if_gnt), 32'(v.fetch && mem_ready));
      check("d_gnt", 32'(d_gnt), 32'(!v.fetch && mem_ready));
    end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; if_flush = 1'b0;
    if (v.fetch || !v.we) begin
      for (int k = 0; k < v.rv_dly; k++) begin
        if_flush = (v.flush == 2 && k == 0);
        @(negedge clk);
        check("wait_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
      end
      if_flush   = (v.flush == 1);
      mem_rvalid = 1'b1;
      mem_rdata  = v.rdata;
      if (!(v.fetch && v.flush >= 1 && v.flush <= 3)) exp_q.push_back('{v.fetch, v.rdata});
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      if_flush   = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_wlen"}, 32'(mem_wlen), 32'd0);
    check({tag, "_gnts"}, 32'({if_gnt, d_gnt}), 32'd0);
    check({tag, "_rvalids"}, 32'({if_rvalid, d_rvalid}), 32'd0);
    check({tag, "_if_rdata"}, if_rdata, 32'd0);
    check({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[10];
    int   dcount;
    bit   got;
    bit   saw_d;

    tbl[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         2'd0, 0, 1, 32'h0050_0093, 0};
    tbl[1] = '{1'b0, 1'b1, 32'h0000_3000, 32'h1234_5678, 2'd1, 0, 0, 32'h0,         0};
    tbl[2] = '{1'b0, 1'b0, 32'h0000_3000, 32'h0,         2'd0, 5, 0, 32'hCAFE_F00D, 0};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         2'd0, 0, 2, 32'h1111_1111, 2};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         2'd0, 0, 1, 32'h00A0_0113, 0};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0108, 32'h0,         2'd0, 0, 0, 32'h5555_5555, 1};
    tbl[6] = '{1'b1, 1'b0, 32'h0000_010C, 32'h0,         2'd0, 2, 1, 32'h6666_6666, 3};
    tbl[7] = '{1'b1, 1'b0, 32'h0000_0110, 32'h0,         2'd0, 0, 0, 32'h2222_2222, 4};
    tbl[8] = '{1'b0, 1'b0, 32'h0000_4000, 32'h0,         2'd0, 1, 3, 32'h3333_3333, 0};
    tbl[9] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 2'd3, 0, 0, 32'h0,         0};

    rstn = 1'b0;
    if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_wlen = 2'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    rstn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("post_rst");
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) txn(tbl[i]);
    @(negedge clk);
    check("if_rdata_hold", if_rdata, 32'h2222_2222);
    check("d_rdata_hold", d_rdata, 32'h3333_3333);
    @(posedge clk); #1;

    // Data priority: both request together, write wins, fetch follows in cycle 3.
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wlen = 2'd2;
    mem_ready = 1'b1;
    @(negedge clk);
    check("prio_c0_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("prio_c1_gnts", 32'({if_gnt, d_gnt}), 32'd1);
    check("prio_c1_mem_we", 32'(mem_we), 32'd1);
    check("prio_c1_mem_addr", mem_addr, 32'h2000);
    check("prio_c1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("prio_c1_mem_wlen", 32'(mem_wlen), 32'd2);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    check("prio_c2_mem_req", 32'(mem_req), 32'd0);
    check("prio_c2_if_gnt", 32'(if_gnt), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("prio_c3_if_gnt", 32'(if_gnt), 32'd1);
    check("prio_c3_mem_we", 32'(mem_we), 32'd0);
    check("prio_c3_mem_addr", mem_addr, 32'h300);
    @(posedge clk); #1;
    if_req = 1'b0; mem_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h4444_4444;
    exp_q.push_back('{1'b1, 32'h4444_4444});
    @(posedge clk); #1;
    mem_rvalid = 1'b0;

    // Starvation bound: with both held, 4 data grants then a fetch grant, twice.
    if_req = 1'b1; if_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h6000; d_wdata = 32'h0; d_wlen = 2'd0;
    mem_ready = 1'b1;
    for (int round = 0; round < 2; round++) begin
      dcount = 0;
      got = 1'b0;
      for (int cyc = 0; cyc < 40 && !got; cyc++) begin
        @(negedge clk);
        saw_d = d_gnt;
        if (d_gnt) dcount++;
        if (if_gnt) got = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        if (saw_d) begin
          d_addr  = d_addr + 32'd4;
          d_wdata = d_wdata + 32'd1;
        end
        if (got) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'h50 + 32'(round);
          exp_q.push_back('{1'b1, 32'h50 + 32'(round)});
          if (round == 1) if_req = 1'b0;
        end
      end
      check("starve_fetch_granted", 32'(got), 32'd1);
      check("starve_data_grants", 32'(dcount), 32'd4);
    end
    got = 1'b0;
    for (int cyc = 0; cyc < 10 && !got; cyc++) begin
      @(negedge clk);
      if (d_gnt) got = 1'b1;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
    check("starve_tail_d_gnt", 32'(got), 32'd1);
    d_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;

    // Async reset while a fetch read is in WAIT.
    if_req = 1'b1; if_addr = 32'h700; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw_if_gnt", 32'(if_gnt), 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0; mem_ready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check_all_zero("rstw");
    @(posedge clk); #1;
    rstn = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("rstw_stray_rvalids", 32'({if_rvalid, d_rvalid}), 32'd0);
    check("rstw_stray_if_rdata", if_rdata, 32'd0);
    check("rstw_stray_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rsp_pending", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
